// File: rtl/cpu_pkg.sv
// Shared opcode, state and decode definitions for the cpu sequencer.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_ROT = 4'h7;
  localparam logic [3:0] OP_BNE = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hC;

  localparam logic [15:0] NOP_INSN = 16'hC000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic pc;
    logic rf;
    logic ill;
    logic mem;
  } exec_t;

  // Pulses raised during EXEC, or a request to enter the MEM phase.
  function automatic exec_t dec_exec(input logic [15:0] insn);
    logic [3:0] op;
    exec_t e;
    op = insn[15:12];
    e  = '0;
    unique case (1'b1)
      (op <= OP_ROT): begin
        e.pc = 1'b1;
        e.rf = 1'b1;
      end
      (op == OP_BNE),
      (op == OP_NOP): e.pc = 1'b1;
      (op == OP_JMP): begin
        e.pc = 1'b1;
        e.rf = insn[10];
      end
      (op == OP_LD),
      (op == OP_ST): e.mem = 1'b1;
      default: begin
        e.pc  = 1'b1;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cpu_seq_wdog.sv
// Bus wait watchdog: counts consecutive wait cycles, flags the TIMEOUT-th.
module cpu_seq_wdog
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expire
);

  logic [7:0] r_cnt;

  assign expire = run && (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || expire) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for a 16-bit cpu.
// Define CPU_SEQ_TIMEOUT_EN to abort bus cycles after TIMEOUT waits.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ack_i,
  input  logic [15:0] dat_i,
  output logic        stb_o,
  output logic        we_o,
  output logic        adr_sel,
  output logic [15:0] ir,
  output logic [15:0] mdr,
  output logic        pc_en,
  output logic        rf_we_en,
  output logic        bus_err,
  output logic        ill_op,
  output logic [2:0]  state
);

  state_t      r_state;
  logic        r_stb;
  logic        r_we;
  logic        r_adr;
  logic [15:0] r_ir;
  logic [15:0] r_mdr;
  logic        r_pc;
  logic        r_rf;
  logic        r_ill;
  logic        r_berr;

  exec_t       w_dec;
  logic [3:0]  w_op;
  logic        w_wait;
  logic        w_expire;

  assign w_dec  = dec_exec(r_ir);
  assign w_op   = r_ir[15:12];
  assign w_wait = r_stb & ~ack_i;

`ifdef CPU_SEQ_TIMEOUT_EN
  cpu_seq_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_wait),
    .clr   (~w_wait),
    .expire(w_expire)
  );
`else
  assign w_expire = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= 1'b0;
      r_ir    <= NOP_INSN;
      r_mdr   <= '0;
      r_pc    <= 1'b0;
      r_rf    <= 1'b0;
      r_ill   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_pc   <= 1'b0;
      r_rf   <= 1'b0;
      r_ill  <= 1'b0;
      r_berr <= 1'b0;
      unique case (r_state)
        S_FETCH: begin
          // Strobe idle here only after reset or an aborted fetch.
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_adr <= 1'b0;
          end else if (ack_i) begin
            r_ir    <= dat_i;
            r_stb   <= 1'b0;
            r_state <= S_DECODE;
          end else if (w_expire) begin
            r_stb  <= 1'b0;
            r_berr <= 1'b1;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
          r_pc    <= w_dec.pc;
          r_rf    <= w_dec.rf;
          r_ill   <= w_dec.ill;
        end
        S_EXEC: begin
          r_stb <= 1'b1;
          if (w_dec.mem) begin
            r_state <= S_MEM;
            r_adr   <= 1'b1;
            r_we    <= (w_op == OP_ST);
          end else begin
            r_state <= S_FETCH;
            r_adr   <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        S_MEM: begin
          if (ack_i) begin
            if (w_op == OP_LD) r_mdr <= dat_i;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= 1'b0;
            r_pc    <= 1'b1;
            r_rf    <= (w_op == OP_LD);
            r_state <= S_WB;
          end else if (w_expire) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= 1'b0;
            r_pc    <= 1'b1;
            r_berr  <= 1'b1;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_stb   <= 1'b1;
          r_we    <= 1'b0;
          r_adr   <= 1'b0;
        end
        default: begin
          r_state <= S_FETCH;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_adr   <= 1'b0;
        end
      endcase
    end
  end

  assign stb_o    = r_stb;
  assign we_o     = r_we;
  assign adr_sel  = r_adr;
  assign ir       = r_ir;
  assign mdr      = r_mdr;
  assign pc_en    = r_pc;
  assign rf_we_en = r_rf;
  assign ill_op   = r_ill;
  assign bus_err  = r_berr;
  assign state    = r_state;

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: instructions retire on pc_en.
module tb_cpu_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack_i = 1'b0;
  logic [15:0] dat_i = 16'h0;
  logic        stb_o, we_o, adr_sel;
  logic [15:0] ir, mdr;
  logic        pc_en, rf_we_en, bus_err, ill_op;
  logic [2:0]  state;

  always #5 clk = ~clk;

  cpu_seq #(.TIMEOUT(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ack_i   (ack_i),
    .dat_i   (dat_i),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .adr_sel (adr_sel),
    .ir      (ir),
    .mdr     (mdr),
    .pc_en   (pc_en),
    .rf_we_en(rf_we_en),
    .bus_err (bus_err),
    .ill_op  (ill_op),
    .state   (state)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rf;
    logic        ill;
    logic [15:0] ir;
    logic [15:0] mdr;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  logic [3:0]  m_cur;
  logic [3:0]  prev_p = 4'b0;
  logic [15:0] last_ir = 16'hC000;
  logic [15:0] last_mdr = 16'h0;

  function automatic exp_t model(input logic [15:0] i,
                                 input logic [15:0] ld,
                                 input bit abort,
                                 input logic [15:0] cur_mdr);
    logic [3:0] op;
    exp_t m;
    op    = i[15:12];
    m.ir  = i;
    m.ill = (op >= 4'hD);
    m.mdr = (op == 4'h9 && !abort) ? ld : cur_mdr;
    if (op <= 4'h7)      m.rf = 1'b1;
    else if (op == 4'hB) m.rf = i[10];
    else if (op == 4'h9) m.rf = !abort;
    else                 m.rf = 1'b0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_p = 4'b0;
    end else begin
      m_cur = {pc_en, rf_we_en, ill_op, bus_err};
      if (m_cur != 4'b0) begin
        checks++;
        if ((m_cur & prev_p) != 4'b0) begin
          errors++;
          $display("FAIL pulse_width got=%b prev=%b want no overlap",
                   m_cur, prev_p);
        end
      end
      if (we_o) begin
        checks++;
        if (state !== 3'd3 || adr_sel !== 1'b1) begin
          errors++;
          $display("FAIL we_scope state=%0d adr_sel=%b want 3/1",
                   state, adr_sel);
        end
      end
      if (pc_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow ir=%h want no retire", ir);
        end else begin
          m_e = sb.pop_front();
          if (rf_we_en !== m_e.rf || ill_op !== m_e.ill ||
              ir !== m_e.ir || mdr !== m_e.mdr) begin
            errors++;
            $display("FAIL retire got rf=%b ill=%b ir=%h mdr=%h want rf=%b ill=%b ir=%h mdr=%h",
                     rf_we_en, ill_op, ir, mdr,
                     m_e.rf, m_e.ill, m_e.ir, m_e.mdr);
          end
        end
      end
      prev_p = m_cur;
    end
  end

  task automatic exec_instr(input logic [15:0] i, input logic [15:0] ld,
                            input int fw, input int mw);
    logic [3:0] op;
    bit mem;
    int c, n;
    op  = i[15:12];
    mem = (op == 4'h9 || op == 4'hA);
    sb.push_back(model(i, ld, 1'b0, last_mdr));
    n = 0;
    while (stb_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (stb_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_strobe got=%b want 1 within 20 cycles", stb_o);
      return;
    end
    c = 1;
    checks++;
    if (adr_sel !== 1'b0 || we_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_bus adr=%b we=%b want 0/0", adr_sel, we_o);
    end
    repeat (fw) begin
      @(negedge clk);
      c++;
      checks++;
      if (stb_o !== 1'b1 || ir !== last_ir) begin
        errors++;
        $display("FAIL fetch_wait stb=%b ir=%h want 1/%h", stb_o, ir, last_ir);
      end
    end
    ack_i = 1'b1;
    dat_i = i;
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 16'h0;
    c++;
    checks++;
    if (state !== 3'd1 || stb_o !== 1'b0 || ir !== i || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL decode state=%0d stb=%b ir=%h berr=%b want 1/0/%h/0",
               state, stb_o, ir, bus_err, i);
    end
    @(negedge clk);
    c++;
    if (!mem) begin
      checks++;
      if (state !== 3'd2 || pc_en !== 1'b1 || c != 3 + fw) begin
        errors++;
        $display("FAIL exec_latency state=%0d pc_en=%b cyc=%0d want 2/1/%0d",
                 state, pc_en, c, 3 + fw);
      end
    end else begin
      checks++;
      if (state !== 3'd2 || pc_en !== 1'b0 || stb_o !== 1'b0) begin
        errors++;
        $display("FAIL exec_mem state=%0d pc_en=%b stb=%b want 2/0/0",
                 state, pc_en, stb_o);
      end
      @(negedge clk);
      c++;
      checks++;
      if (state !== 3'd3 || stb_o !== 1'b1 || adr_sel !== 1'b1 ||
          we_o !== (op == 4'hA)) begin
        errors++;
        $display("FAIL mem_bus state=%0d stb=%b adr=%b we=%b want 3/1/1/%b",
                 state, stb_o, adr_sel, we_o, (op == 4'hA));
      end
      repeat (mw) begin
        @(negedge clk);
        c++;
        checks++;
        if (stb_o !== 1'b1 || mdr !== last_mdr) begin
          errors++;
          $display("FAIL mem_wait stb=%b mdr=%h want 1/%h", stb_o, mdr, last_mdr);
        end
      end
      ack_i = 1'b1;
      dat_i = ld;
      @(negedge clk);
      ack_i = 1'b0;
      dat_i = 16'h0;
      c++;
      checks++;
      if (state !== 3'd4 || pc_en !== 1'b1 || stb_o !== 1'b0 ||
          we_o !== 1'b0 || bus_err !== 1'b0 || c != 5 + fw + mw) begin
        errors++;
        $display("FAIL wb_latency state=%0d pc_en=%b stb=%b berr=%b cyc=%0d want 4/1/0/0/%0d",
                 state, pc_en, stb_o, bus_err, c, 5 + fw + mw);
      end
      if (op == 4'h9) last_mdr = ld;
    end
    last_ir = i;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || stb_o !== 1'b1 || adr_sel !== 1'b0) begin
      errors++;
      $display("FAIL refetch state=%0d stb=%b adr=%b want 0/1/0",
               state, stb_o, adr_sel);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || ir !== 16'hC000 || mdr !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs state=%0d ir=%h mdr=%h want 0/c000/0000",
               state, ir, mdr);
    end
    checks++;
    if ({stb_o, we_o, adr_sel, pc_en, rf_we_en, bus_err, ill_op} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs got=%b want 0000000",
               {stb_o, we_o, adr_sel, pc_en, rf_we_en, bus_err, ill_op});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (stb_o !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_first_stb stb=%b state=%0d want 1/0", stb_o, state);
    end
  endtask

  task automatic test_alu();
    exec_instr(16'h0123, 16'h0, 0, 0);
    exec_instr(16'h1ABC, 16'h0, 1, 0);
    exec_instr(16'h7FFF, 16'h0, 3, 0);
  endtask

  task automatic test_load();
    exec_instr(16'h9400, 16'h5A5A, 2, 2);
    exec_instr(16'h9000, 16'hA5C3, 0, 0);
  endtask

  task automatic test_store();
    exec_instr(16'hA000, 16'hFFFF, 0, 0);
    exec_instr(16'hA123, 16'h1111, 1, 2);
  endtask

  task automatic test_jmp_ill();
    exec_instr(16'hB400, 16'h0, 0, 0);
    exec_instr(16'hB800, 16'h0, 0, 0);
    exec_instr(16'hBC00, 16'h0, 0, 0);
    exec_instr(16'hE000, 16'h0, 0, 0);
    exec_instr(16'hD001, 16'h0, 1, 0);
    exec_instr(16'hF0F0, 16'h0, 0, 0);
    exec_instr(16'hC000, 16'h0, 0, 0);
    exec_instr(16'h8000, 16'h0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [8];
    prog = '{16'h2345, 16'h9001, 16'hA002, 16'h6543,
             16'hB401, 16'h9FFF, 16'hE111, 16'h3333};
    for (int k = 0; k < 8; k++) begin
      exec_instr(prog[k], 16'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_mid_reset();
    ack_i = 1'b1;
    dat_i = 16'h9400;
    @(negedge clk);
    ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || stb_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup state=%0d stb=%b want 3/1", state, stb_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (stb_o !== 1'b0 || ir !== 16'hC000 || state !== 3'd0 || mdr !== 16'h0) begin
      errors++;
      $display("FAIL midrst_async stb=%b ir=%h state=%0d mdr=%h want 0/c000/0/0000",
               stb_o, ir, state, mdr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (stb_o !== 1'b1 || adr_sel !== 1'b0) begin
      errors++;
      $display("FAIL midrst_restart stb=%b adr=%b want 1/0", stb_o, adr_sel);
    end
    last_ir  = 16'hC000;
    last_mdr = 16'h0;
    exec_instr(16'h4444, 16'h0, 0, 0);
  endtask

`ifdef CPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    repeat (14) begin
      @(negedge clk);
      checks++;
      if (stb_o !== 1'b1 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL to_fetch_wait stb=%b berr=%b want 1/0", stb_o, bus_err);
      end
    end
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b1 || stb_o !== 1'b0 || state !== 3'd0 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL to_fetch_abort berr=%b stb=%b state=%0d pc=%b want 1/0/0/0",
               bus_err, stb_o, state, pc_en);
    end
    @(negedge clk);
    checks++;
    if (stb_o !== 1'b1 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL to_fetch_retry stb=%b berr=%b want 1/0", stb_o, bus_err);
    end
    sb.push_back(model(16'h9400, 16'h0, 1'b1, last_mdr));
    ack_i = 1'b1;
    dat_i = 16'h9400;
    @(negedge clk);
    ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    repeat (14) begin
      @(negedge clk);
      checks++;
      if (stb_o !== 1'b1 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL to_mem_wait stb=%b berr=%b want 1/0", stb_o, bus_err);
      end
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || bus_err !== 1'b1 || pc_en !== 1'b1 || rf_we_en !== 1'b0) begin
      errors++;
      $display("FAIL to_mem_abort state=%0d berr=%b pc=%b rf=%b want 4/1/1/0",
               state, bus_err, pc_en, rf_we_en);
    end
    last_ir = 16'h9400;
    @(negedge clk);
    exec_instr(16'h9400, 16'h7E7E, 14, 14);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL global_time_limit reached=%0t want finish earlier", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jmp_ill();
    test_back_to_back();
    test_mid_reset();
`ifdef CPU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter: TIMEOUT, default 15, bus-wait cycles before abort (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ack_i  in  1  bus acknowledge; ignored while stb_o=0.
REQ-005 dat_i  in  16  bus read data (instruction or load data).
REQ-006 stb_o  out  1  bus strobe; held high until ack_i or abort.
REQ-007 we_o  out  1  bus write (ST data phase only).
REQ-008 adr_sel  out  1  0 = PC address, 1 = data address.
REQ-009 ir  out  16  instruction register feeding the decode unit.
REQ-010 mdr  out  16  load data register.
REQ-011 pc_en  out  1  one-cycle PC advance pulse.
REQ-012 rf_we_en  out  1  one-cycle gate ANDed with decoder RF_WE.
REQ-013 bus_err  out  1  one-cycle abort pulse.
REQ-014 ill_op  out  1  one-cycle pulse, opcode 4'b1101..4'b1111.
REQ-015 state  out  3  current FSM state, debug.

Function
REQ-016 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB; unused encodings SHALL return to FETCH.
REQ-017 FETCH: stb_o=1, we_o=0, adr_sel=0; on ack_i, ir<=dat_i and go to DECODE; stb_o low next cycle.
REQ-018 DECODE: one cycle, no bus activity; go to EXEC.
REQ-019 EXEC, ir[15:12] in ADD..ROT: pc_en=1, rf_we_en=1, go to FETCH.
REQ-020 EXEC, BNE or NOP: pc_en=1, rf_we_en=0, go to FETCH.
REQ-021 EXEC, JMP: pc_en=1; rf_we_en=1 only when ir[11:10] is 2'b01 or 2'b11; go to FETCH.
REQ-022 EXEC, opcode 1101..1111: behave as NOP and assert ill_op for that cycle.
REQ-023 EXEC, LD or ST: go to MEM, no pulses.
REQ-024 MEM: stb_o=1, adr_sel=1, we_o=1 iff ST; on ack_i, LD latches mdr<=dat_i; go to WB.
REQ-025 WB: pc_en=1; rf_we_en=1 iff LD and no abort occurred in MEM; go to FETCH.
REQ-026 Latency with zero-wait ack (ack_i in first strobe cycle): ALU/BNE/JMP/NOP 3 cycles, LD/ST 5 cycles per instruction.
REQ-027 Each wait cycle (stb_o=1, ack_i=0) SHALL add exactly one cycle; ir and mdr SHALL hold value.
REQ-028 pc_en, rf_we_en, ill_op, bus_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-029 rst_n low SHALL force immediately: state=FETCH, ir=16'hC000 (NOP), mdr=0, stb_o=0, we_o=0, adr_sel=0, all pulses 0, wait counter 0.
REQ-030 First stb_o SHALL rise in the first clock cycle after rst_n deasserts; reset mid-bus-cycle SHALL drop stb_o asynchronously.

Configuration
REQ-031 Macro CPU_SEQ_TIMEOUT_EN defined: wait counter counts consecutive stb_o=1/ack_i=0 cycles; reaching TIMEOUT SHALL pulse bus_err, drop stb_o, and clear the counter.
REQ-032 With macro: FETCH abort returns to FETCH with no pc_en (retry); MEM abort goes to WB with rf_we_en suppressed (instruction skipped).
REQ-033 Without macro: no counter, bus_err tied 0, FSM waits on ack_i indefinitely.
REQ-034 Simultaneous ack_i and timeout in the same cycle: ack_i SHALL win, no bus_err.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the 4-bit opcode constants (ADD=0000..NOP=1100), the state encoding, and the NOP instruction word.
REQ-036 Wait counter SHALL be sub-module cpu_seq_wdog (inputs clk, rst_n, run, clr; output expire), instantiated only under CPU_SEQ_TIMEOUT_EN.

Verification
REQ-037 ADD 16'h0123 fetched with zero-wait ack -> ir=16'h0123 at cycle 1, pc_en and rf_we_en high together at cycle 3, state back to FETCH.
REQ-038 LD 16'h9400 with 2 wait cycles on each phase -> mdr=dat_i load value, rf_we_en+pc_en in WB at cycle 9, we_o never high.
REQ-039 ST 16'hA000 -> we_o=1 and adr_sel=1 only during MEM, rf_we_en stays 0, pc_en pulses once.
REQ-040 JMP 16'hB400 -> rf_we_en=1; JMP 16'hB800 -> rf_we_en=0; opcode 16'hE000 -> ill_op pulse, pc_en=1.
REQ-041 With CPU_SEQ_TIMEOUT_EN and TIMEOUT=15, no ack in MEM -> bus_err at wait cycle 15, WB with pc_en=1, rf_we_en=0; ack at cycle 15 -> no bus_err.
REQ-042 rst_n asserted mid-MEM with stb_o=1 -> stb_o=0 and ir=16'hC000 before next clock edge; restart fetch after release.
